// File: rtl/hit_keypad_scanner.sv
// 4x4 matrix keypad scanner with frame debounce and ghosting rejection for the mole game.
// Optional auto-repeat while a key is held: define HIT_AUTOREPEAT_EN.
module hit_keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 4,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic        clk,
  input  logic        game_reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] hit_point,
  output logic [3:0]  key_code,
  output logic        key_held
);

  localparam int unsigned DwellW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [3:0] DbLast = 4'(DEBOUNCE);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPressDb = 2'd1;
  localparam logic [1:0] StHeld    = 2'd2;
  localparam logic [1:0] StRelDb   = 2'd3;

  logic [3:0]        row_s1_q, row_s2_q;
  logic [1:0]        col_q, col_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [15:0]       frame_q, frame_d;
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d, cnt_inc;
  logic [3:0]        cand_q, cand_d;
  logic [15:0]       hit_q, hit_d;
  logic [3:0]        code_q, code_d;
  logic              held_q, held_d;
  logic              sample_en, frame_end, is_one, accept;
  logic [4:0]        nkeys;
  logic [3:0]        one_idx;

`ifdef HIT_AUTOREPEAT_EN
  localparam int unsigned RptW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_FRAMES - 1);
  logic [RptW-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    sample_en = (dwell_q == DwellLast);
    frame_end = sample_en && (col_q == 2'd3);
    dwell_d   = sample_en ? '0 : dwell_q + 1'b1;
    col_d     = sample_en ? col_q + 2'd1 : col_q;

    col_out        = 4'b1111;
    col_out[col_q] = 1'b0;

    // Merge the current column's sample so the frame_end classification sees column 3.
    frame_d = frame_q;
    if (sample_en) begin
      for (int r = 0; r < 4; r++) frame_d[{r[1:0], col_q}] = ~row_s2_q[r];
    end

    nkeys   = '0;
    one_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_d[i]) begin
        nkeys   = nkeys + 5'd1;
        one_idx = 4'(i);
      end
    end
    is_one = (nkeys == 5'd1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    held_d  = held_q;
    hit_d   = '0;
    accept  = 1'b0;
    cnt_inc = (cnt_q == DbLast) ? cnt_q : cnt_q + 4'd1;
`ifdef HIT_AUTOREPEAT_EN
    rpt_d = rpt_q;
`endif

    if (frame_end) begin
      case (state_q)
        StIdle: begin
          if (is_one) begin
            cand_d  = one_idx;
            cnt_d   = 4'd1;
            state_d = StPressDb;
            accept  = (DbLast == 4'd1);
          end
        end
        StPressDb: begin
          if (!is_one) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (one_idx == cand_q) begin
            cnt_d  = cnt_inc;
            accept = (cnt_inc == DbLast);
          end else begin
            cand_d = one_idx;
            cnt_d  = 4'd1;
          end
        end
        StHeld: begin
          if (!is_one) begin
            if (DbLast == 4'd1) begin
              state_d = StIdle;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = StRelDb;
              cnt_d   = 4'd1;
            end
          end else begin
`ifdef HIT_AUTOREPEAT_EN
            if (rpt_q == RptLast) begin
              rpt_d = '0;
              hit_d = 16'h0001 << code_q;
            end else begin
              rpt_d = rpt_q + 1'b1;
            end
`endif
          end
        end
        default: begin
          if (is_one) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else if (cnt_inc == DbLast) begin
            state_d = StIdle;
            held_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end

    if (accept) begin
      state_d = StHeld;
      cnt_d   = DbLast;
      code_d  = cand_d;
      held_d  = 1'b1;
      hit_d   = 16'h0001 << cand_d;
    end
`ifdef HIT_AUTOREPEAT_EN
    if (accept || state_d != StHeld) rpt_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge game_reset) begin
    if (game_reset) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
      col_q    <= '0;
      dwell_q  <= '0;
      frame_q  <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      cand_q   <= '0;
      hit_q    <= '0;
      code_q   <= '0;
      held_q   <= 1'b0;
`ifdef HIT_AUTOREPEAT_EN
      rpt_q    <= '0;
`endif
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
      col_q    <= col_d;
      dwell_q  <= dwell_d;
      frame_q  <= frame_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      hit_q    <= hit_d;
      code_q   <= code_d;
      held_q   <= held_d;
`ifdef HIT_AUTOREPEAT_EN
      rpt_q    <= rpt_d;
`endif
    end
  end

  assign hit_point = hit_q;
  assign key_code  = code_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_hit_keypad_scanner.sv
// Self-checking bench for hit_keypad_scanner: keypad matrix model plus a pulse scoreboard.
module tb_hit_keypad_scanner;

  logic        clk;
  logic        game_reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] hit_point;
  logic [3:0]  key_code;
  logic        key_held;

  logic [15:0] press;
  logic [15:0] exp_q[$];
  int          checks;
  int          errors;

  hit_keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE      (3),
    .REPEAT_FRAMES (8)
  ) dut (
    .clk        (clk),
    .game_reset (game_reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .hit_point  (hit_point),
    .key_code   (key_code),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed switch at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (press[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Scoreboard: every nonzero hit_point cycle must match the next expected pulse.
  always @(negedge clk) begin
    if (!game_reset && hit_point !== 16'h0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got %h, required no pulse", hit_point);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (hit_point !== e) begin
          errors++;
          $display("FAIL pulse_value: got %h, required %h", hit_point, e);
        end
      end
    end
  end

  // Returns #1 after the edge where col_out wraps 0111 -> 1110 (first cycle of a new frame).
  task automatic next_frame();
    logic [3:0] prev;
    prev = col_out;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (prev == 4'b0111 && col_out == 4'b1110) return;
      prev = col_out;
    end
    errors++;
    $display("FAIL frame_timeout: got no column wrap in 40 clocks, required one");
  endtask

  task automatic release_and_idle();
    press = 16'h0000;
    for (int f = 0; f < 3; f++) next_frame();
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL release_held: got %b, required 0", key_held);
    end
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    checks++;
    if (col_out !== 4'b1110 || hit_point !== 16'h0 || key_code !== 4'h0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got col=%b hit=%h code=%h held=%b, required 1110/0000/0/0",
               col_out, hit_point, key_code, key_held);
    end
    @(negedge clk);
    game_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (col_out !== seq[i/4]) begin
        errors++;
        $display("FAIL col_sequence[%0d]: got %b, required %b", i, col_out, seq[i/4]);
      end
      @(negedge clk);
    end
    // Press key 6 and assert reset mid-debounce; the pending accept must vanish.
    next_frame();
    press = 16'h0040;
    next_frame();
    next_frame();
    repeat (5) @(posedge clk);
    #3;
    game_reset = 1'b1;
    #1;
    checks++;
    if (col_out !== 4'b1110 || hit_point !== 16'h0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got col=%b hit=%h held=%b, required 1110/0000/0",
               col_out, hit_point, key_held);
    end
    press = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    game_reset = 1'b0;
    for (int f = 0; f < 4; f++) next_frame();
    checks++;
    if (key_held !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_drop: got held=%b pending=%0d, required 0/0", key_held, exp_q.size());
    end
  endtask

  task automatic test_clean_press();
    next_frame();
    press = 16'h0200;
    exp_q.push_back(16'h0200);
    for (int f = 1; f <= 2; f++) begin
      next_frame();
      checks++;
      if (hit_point !== 16'h0 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL clean_early[%0d]: got hit=%h held=%b, required 0000/0", f, hit_point, key_held);
      end
    end
    next_frame();
    checks++;
    if (hit_point !== 16'h0200 || key_code !== 4'd9 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL clean_accept: got hit=%h code=%0d held=%b, required 0200/9/1",
               hit_point, key_code, key_held);
    end
    @(posedge clk);
    #1;
    checks++;
    if (hit_point !== 16'h0) begin
      errors++;
      $display("FAIL clean_width: got %h one clk later, required 0000", hit_point);
    end
    next_frame();
    next_frame();
    press = 16'h0000;
    for (int f = 1; f <= 2; f++) begin
      next_frame();
      checks++;
      if (key_held !== 1'b1) begin
        errors++;
        $display("FAIL clean_rel_early[%0d]: got held=%b, required 1", f, key_held);
      end
    end
    next_frame();
    checks++;
    if (key_held !== 1'b0 || key_code !== 4'd9) begin
      errors++;
      $display("FAIL clean_release: got held=%b code=%0d, required 0/9", key_held, key_code);
    end
  endtask

  task automatic test_bounce();
    next_frame();
    press = 16'h0020;
    next_frame();
    next_frame();
    press = 16'h0000;
    next_frame();
    press = 16'h0020;
    exp_q.push_back(16'h0020);
    for (int f = 1; f <= 2; f++) begin
      next_frame();
      checks++;
      if (hit_point !== 16'h0) begin
        errors++;
        $display("FAIL bounce_early[%0d]: got %h, required 0000", f, hit_point);
      end
    end
    next_frame();
    checks++;
    if (hit_point !== 16'h0020 || key_code !== 4'd5) begin
      errors++;
      $display("FAIL bounce_accept: got hit=%h code=%0d, required 0020/5", hit_point, key_code);
    end
    release_and_idle();
  endtask

  task automatic test_multi();
    next_frame();
    press = 16'h8001;
    for (int f = 1; f <= 6; f++) begin
      next_frame();
      checks++;
      if (hit_point !== 16'h0 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL multi_reject[%0d]: got hit=%h held=%b, required 0000/0", f, hit_point, key_held);
      end
    end
    press = 16'h0001;
    exp_q.push_back(16'h0001);
    next_frame();
    next_frame();
    next_frame();
    checks++;
    if (hit_point !== 16'h0001 || key_code !== 4'd0 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL multi_single: got hit=%h code=%0d held=%b, required 0001/0/1",
               hit_point, key_code, key_held);
    end
    release_and_idle();
  endtask

  task automatic test_release_glitch();
    next_frame();
    press = 16'h0008;
    exp_q.push_back(16'h0008);
    for (int f = 0; f < 3; f++) next_frame();
    press = 16'h0000;
    next_frame();
    next_frame();
    press = 16'h0008;
    for (int f = 1; f <= 3; f++) begin
      next_frame();
      checks++;
      if (key_held !== 1'b1 || hit_point !== 16'h0) begin
        errors++;
        $display("FAIL glitch_hold[%0d]: got held=%b hit=%h, required 1/0000", f, key_held, hit_point);
      end
    end
    release_and_idle();
  endtask

  task automatic test_back_to_back();
    next_frame();
    press = 16'h0008;
    exp_q.push_back(16'h0008);
    for (int f = 0; f < 3; f++) next_frame();
    press = 16'h0080;
    for (int f = 1; f <= 4; f++) begin
      next_frame();
      checks++;
      if (key_held !== 1'b1 || key_code !== 4'd3) begin
        errors++;
        $display("FAIL switch_ignored[%0d]: got held=%b code=%0d, required 1/3", f, key_held, key_code);
      end
    end
    release_and_idle();
    press = 16'h0080;
    exp_q.push_back(16'h0080);
    for (int f = 0; f < 3; f++) next_frame();
    checks++;
    if (hit_point !== 16'h0080 || key_code !== 4'd7) begin
      errors++;
      $display("FAIL second_press: got hit=%h code=%0d, required 0080/7", hit_point, key_code);
    end
    release_and_idle();
  endtask

  task automatic test_autorepeat();
    int npulse;
    logic [15:0] want;
    npulse = 0;
    next_frame();
    press = 16'h1000;
    exp_q.push_back(16'h1000);
`ifdef HIT_AUTOREPEAT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h1000);
`endif
    for (int f = 1; f <= 30; f++) begin
      next_frame();
      want = (f == 3) ? 16'h1000 : 16'h0000;
`ifdef HIT_AUTOREPEAT_EN
      if (f > 3 && (f - 3) % 8 == 0) want = 16'h1000;
`endif
      if (hit_point !== 16'h0) npulse++;
      checks++;
      if (hit_point !== want) begin
        errors++;
        $display("FAIL repeat_frame[%0d]: got %h, required %h", f, hit_point, want);
      end
    end
    checks++;
`ifdef HIT_AUTOREPEAT_EN
    if (npulse != 4) begin
      errors++;
      $display("FAIL repeat_count: got %0d, required 4", npulse);
    end
`else
    if (npulse != 1) begin
      errors++;
      $display("FAIL repeat_count: got %0d, required 1", npulse);
    end
`endif
    release_and_idle();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    press      = 16'h0000;
    game_reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_release_glitch();
    test_back_to_back();
    test_autorepeat();
    next_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: got %0d unseen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
